exception_ctrl: RTL and testbench

//  Parametrised, sequential exception controller for the pipelined core. It qualifies

---
 rtl/exception_ctrl.sv | 179 +++++++++++++++++
 tb/tb_exception_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// exception_ctrl: sequential exception controller for the pipelined core.
// Qualifies ALU faults by opcode, merges external cause requests, masks and
// prioritises them (lowest index wins), captures cause/EPC, pulses a vectored
// redirect, tracks the handler until eret and queues requests raised while a
// handler is in flight in a small pending FIFO.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   valid_i, opcode_i    EX-stage instruction qualifiers
//   pc_i                 EX-stage instruction PC
//   div_by_zero_i        divider fault (cause 0, qualified by OP_DIV)
//   ovf_add_i/ovf_sub_i  adder/subtractor overflow (cause 1, by OP_ADD/OP_SUB)
//   ext_req_i            external requests, bit k = cause k+2
//   mask_i               1 = cause disabled
//   eret_i               handler return strobe
//   clr_sticky_i         clears pend_ovf_o
//   exception_o          1-cycle redirect pulse, handler_address_o valid with it
//   cause_o, epc_o       captured cause and faulting PC
//   busy_o               handler active
//   ret_o, ret_pc_o      1-cycle return pulse with return PC
//   pend_ovf_o           sticky: a queued request was dropped
module exception_ctrl #(
  parameter int unsigned          ADDR_W     = 19,
  parameter int unsigned          OPCODE_W   = 5,
  parameter int unsigned          NUM_CAUSES = 4,
  parameter int unsigned          PEND_DEPTH = 4,
  parameter logic [ADDR_W-1:0]    VEC_BASE   = ADDR_W'(19'h7fff0),
  parameter int unsigned          VEC_STRIDE = 1,
  parameter logic [OPCODE_W-1:0]  OP_ADD     = OPCODE_W'(0),
  parameter logic [OPCODE_W-1:0]  OP_SUB     = OPCODE_W'(1),
  parameter logic [OPCODE_W-1:0]  OP_DIV     = OPCODE_W'(3),
  localparam int unsigned         CW         = (NUM_CAUSES > 2) ? $clog2(NUM_CAUSES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [OPCODE_W-1:0]   opcode_i,
  input  logic [ADDR_W-1:0]     pc_i,
  input  logic                  div_by_zero_i,
  input  logic                  ovf_add_i,
  input  logic                  ovf_sub_i,
  input  logic [NUM_CAUSES-3:0] ext_req_i,
  input  logic [NUM_CAUSES-1:0] mask_i,
  input  logic                  eret_i,
  input  logic                  clr_sticky_i,
  output logic                  exception_o,
  output logic [ADDR_W-1:0]     handler_address_o,
  output logic [CW-1:0]         cause_o,
  output logic [ADDR_W-1:0]     epc_o,
  output logic                  busy_o,
  output logic                  ret_o,
  output logic [ADDR_W-1:0]     ret_pc_o,
  output logic                  pend_ovf_o
);

  localparam int unsigned PW = $clog2(PEND_DEPTH);
  localparam int unsigned EW = CW + ADDR_W;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(PEND_DEPTH);

  typedef enum logic [1:0] {IDLE, TAKE, HANDLER, RETURN} state_t;

  state_t state, state_next;

  logic [NUM_CAUSES-1:0] req;
  logic                  req_any;
  logic [CW-1:0]         req_cause;

  // Request qualification and masking
  always_comb begin
    req    = '0;
    req[0] = valid_i && (opcode_i == OP_DIV) && div_by_zero_i;
    req[1] = valid_i && (((opcode_i == OP_ADD) && ovf_add_i) ||
                         ((opcode_i == OP_SUB) && ovf_sub_i));
    for (int unsigned k = 2; k < NUM_CAUSES; k++) begin
      req[k] = valid_i && ext_req_i[k-2];
    end
    req = req & ~mask_i;
  end

  // Lowest-index priority; the remaining same-cycle bits are discarded
  always_comb begin
    req_any   = 1'b0;
    req_cause = '0;
    for (int unsigned k = 0; k < NUM_CAUSES; k++) begin
      if (!req_any && req[k]) begin
        req_any   = 1'b1;
        req_cause = CW'(k);
      end
    end
  end

  // Pending FIFO of {cause, pc}
  logic [EW-1:0] mem [PEND_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fifo_empty, fifo_full, pop, push, push_ok, drop;
  logic [EW-1:0] head;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = (state == IDLE) && !fifo_empty;
  // In IDLE a request is taken directly unless the FIFO head has precedence
  assign push       = req_any && ((state != IDLE) || !fifo_empty);
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && !push_ok;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {req_cause, pc_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pend_ovf_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      // A drop in the same cycle as a clear keeps the flag set
      if (drop)              pend_ovf_o <= 1'b1;
      else if (clr_sticky_i) pend_ovf_o <= 1'b0;
    end
  end

  // Cause / EPC capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_o <= '0;
      epc_o   <= '0;
    end else if (pop) begin
      cause_o <= head[EW-1:ADDR_W];
      epc_o   <= head[ADDR_W-1:0];
    end else if ((state == IDLE) && req_any) begin
      cause_o <= req_cause;
      epc_o   <= pc_i;
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    exception_o = 1'b0;
    busy_o      = 1'b0;
    ret_o       = 1'b0;
    case (state)
      IDLE:    if (pop || req_any) state_next = TAKE;
      TAKE: begin
        exception_o = 1'b1;
        busy_o      = 1'b1;
        state_next  = HANDLER;
      end
      HANDLER: begin
        busy_o = 1'b1;
        if (eret_i) state_next = RETURN;
      end
      RETURN: begin
        ret_o      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic [ADDR_W-1:0] vec_off;
  assign vec_off           = ADDR_W'(32'(cause_o) * VEC_STRIDE);
  assign handler_address_o = exception_o ? (VEC_BASE + vec_off) : '0;
  assign ret_pc_o          = ret_o ? epc_o : '0;

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

  logic        clk, rst_n;
  logic        valid_i;
  logic [4:0]  opcode_i;
  logic [18:0] pc_i;
  logic        div_by_zero_i, ovf_add_i, ovf_sub_i;
  logic [1:0]  ext_req_i;
  logic [3:0]  mask_i;
  logic        eret_i, clr_sticky_i;
  logic        exception_o;
  logic [18:0] handler_address_o;
  logic [1:0]  cause_o;
  logic [18:0] epc_o;
  logic        busy_o, ret_o;
  logic [18:0] ret_pc_o;
  logic        pend_ovf_o;

  int vectors = 0;
  int miscompares = 0;

  exception_ctrl #(
    .ADDR_W(19), .OPCODE_W(5), .NUM_CAUSES(4), .PEND_DEPTH(4),
    .VEC_BASE(19'h7fff0), .VEC_STRIDE(1),
    .OP_ADD(5'd0), .OP_SUB(5'd1), .OP_DIV(5'd3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .opcode_i(opcode_i), .pc_i(pc_i),
    .div_by_zero_i(div_by_zero_i), .ovf_add_i(ovf_add_i), .ovf_sub_i(ovf_sub_i),
    .ext_req_i(ext_req_i), .mask_i(mask_i), .eret_i(eret_i), .clr_sticky_i(clr_sticky_i),
    .exception_o(exception_o), .handler_address_o(handler_address_o), .cause_o(cause_o),
    .epc_o(epc_o), .busy_o(busy_o), .ret_o(ret_o), .ret_pc_o(ret_pc_o),
    .pend_ovf_o(pend_ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        exc;
    logic [18:0] ha;
    logic [1:0]  cause;
    logic [18:0] epc;
    logic        busy;
    logic        ret;
    logic [18:0] rpc;
    logic        povf;
  } out_t;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_TAKE = 1, M_HANDLER = 2, M_RETURN = 3;
  typedef struct { int c; logic [18:0] pc; } ent_t;
  ent_t        q[$];
  int          ph;
  int          m_cause;
  logic [18:0] m_epc;
  logic        m_ovf;

  function automatic void model_reset();
    q.delete();
    ph = M_IDLE; m_cause = 0; m_epc = '0; m_ovf = 1'b0;
  endfunction

  // Winning cause index for the current inputs, -1 if none
  function automatic int req_cause();
    logic [3:0] r;
    if (!valid_i) return -1;
    r[0] = (opcode_i == 5'd3) && div_by_zero_i;
    r[1] = ((opcode_i == 5'd0) && ovf_add_i) || ((opcode_i == 5'd1) && ovf_sub_i);
    r[2] = ext_req_i[0];
    r[3] = ext_req_i[1];
    for (int k = 0; k < 4; k++) if (r[k] && !mask_i[k]) return k;
    return -1;
  endfunction

  function automatic void m_push(int c);
    ent_t e;
    if (c < 0) return;
    if (q.size() < 4) begin
      e.c = c; e.pc = pc_i;
      q.push_back(e);
    end else m_ovf = 1'b1;
  endfunction

  function automatic void model_edge();
    int   c;
    ent_t e;
    if (!rst_n) return;
    c = req_cause();
    if (clr_sticky_i) m_ovf = 1'b0;
    case (ph)
      M_IDLE:
        if (q.size() != 0) begin
          e = q.pop_front();
          m_cause = e.c; m_epc = e.pc;
          m_push(c);
          ph = M_TAKE;
        end else if (c >= 0) begin
          m_cause = c; m_epc = pc_i;
          ph = M_TAKE;
        end
      M_TAKE:    begin m_push(c); ph = M_HANDLER; end
      M_HANDLER: begin m_push(c); if (eret_i) ph = M_RETURN; end
      default:   begin m_push(c); ph = M_IDLE; end
    endcase
  endfunction

  function automatic out_t model_out();
    out_t o;
    int   h;
    h      = (32'h7fff0 + m_cause * 1) % 524288;
    o.exc  = (ph == M_TAKE);
    o.ha   = o.exc ? h[18:0] : 19'd0;
    o.cause = m_cause[1:0];
    o.epc  = m_epc;
    o.busy = (ph == M_TAKE) || (ph == M_HANDLER);
    o.ret  = (ph == M_RETURN);
    o.rpc  = o.ret ? m_epc : 19'd0;
    o.povf = m_ovf;
    return o;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {exception_o, handler_address_o, cause_o, epc_o, busy_o, ret_o, ret_pc_o, pend_ovf_o};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got exc=%b ha=%h cause=%0d epc=%h busy=%b ret=%b rpc=%h ovf=%b | want exc=%b ha=%h cause=%0d epc=%h busy=%b ret=%b rpc=%h ovf=%b",
               name, act.exc, act.ha, act.cause, act.epc, act.busy, act.ret, act.rpc, act.povf,
               exp.exc, exp.ha, exp.cause, exp.epc, exp.busy, exp.ret, exp.rpc, exp.povf);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    valid_i = 0; opcode_i = '0; pc_i = '0; div_by_zero_i = 0; ovf_add_i = 0;
    ovf_sub_i = 0; ext_req_i = '0; mask_i = '0; eret_i = 0; clr_sticky_i = 0;
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check(name, model_out());
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset", model_out());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic take_div0(input logic [18:0] pc);
    valid_i = 1; opcode_i = 5'd3; div_by_zero_i = 1; pc_i = pc;
    step("take");
    clear_inputs();
  endtask

  // ---------------- single-request table ----------------
  typedef struct {
    logic        valid;
    logic [4:0]  op;
    logic [18:0] pc;
    logic        d0, ad, sb;
    logic [1:0]  ext;
    logic [3:0]  mask;
    logic        exc;
    logic [18:0] ha;
    logic [1:0]  cause;
    logic [18:0] epc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    out_t exp;
    tbl[0] = '{1, 5'd3, 19'h00100, 1, 0, 0, 2'b00, 4'b0000, 1, 19'h7fff0, 2'd0, 19'h00100};
    tbl[1] = '{1, 5'd0, 19'h00123, 1, 1, 0, 2'b00, 4'b0000, 1, 19'h7fff1, 2'd1, 19'h00123};
    tbl[2] = '{1, 5'd3, 19'h00100, 1, 0, 0, 2'b00, 4'b0001, 0, 19'h00000, 2'd0, 19'h00000};
    tbl[3] = '{1, 5'd1, 19'h00055, 0, 0, 1, 2'b00, 4'b0000, 1, 19'h7fff1, 2'd1, 19'h00055};
    tbl[4] = '{1, 5'd0, 19'h00066, 0, 0, 1, 2'b00, 4'b0000, 0, 19'h00000, 2'd0, 19'h00000};
    tbl[5] = '{1, 5'd7, 19'h7ffff, 0, 0, 0, 2'b10, 4'b0000, 1, 19'h7fff3, 2'd3, 19'h7ffff};
    tbl[6] = '{1, 5'd0, 19'h00042, 0, 1, 0, 2'b01, 4'b0010, 1, 19'h7fff2, 2'd2, 19'h00042};
    tbl[7] = '{0, 5'd3, 19'h00077, 1, 1, 1, 2'b11, 4'b0000, 0, 19'h00000, 2'd0, 19'h00000};
    tbl[8] = '{1, 5'd3, 19'h00010, 1, 0, 0, 2'b11, 4'b0000, 1, 19'h7fff0, 2'd0, 19'h00010};
    tbl[9] = '{1, 5'd3, 19'h00011, 0, 1, 1, 2'b00, 4'b0000, 0, 19'h00000, 2'd0, 19'h00000};

    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    exp = '0;
    check("por_state", exp);
    #20;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      do_reset();
      valid_i = tbl[i].valid; opcode_i = tbl[i].op; pc_i = tbl[i].pc;
      div_by_zero_i = tbl[i].d0; ovf_add_i = tbl[i].ad; ovf_sub_i = tbl[i].sb;
      ext_req_i = tbl[i].ext; mask_i = tbl[i].mask;
      step("tbl_model");
      exp = '0;
      exp.exc = tbl[i].exc; exp.ha = tbl[i].ha; exp.cause = tbl[i].cause;
      exp.epc = tbl[i].epc; exp.busy = tbl[i].exc;
      check($sformatf("tbl[%0d]", i), exp);
      clear_inputs();
    end

    // Queued request replays two cycles after the return pulse
    do_reset();
    take_div0(19'h00100);
    step("s3_handler");
    valid_i = 1; ext_req_i = 2'b01; pc_i = 19'h00200;
    step("s3_push");
    clear_inputs();
    eret_i = 1;
    step("s3_eret");
    check_val("s3_ret", {31'd0, ret_o}, 32'd1);
    check_val("s3_ret_pc", {13'd0, ret_pc_o}, 32'h100);
    eret_i = 0;
    step("s3_idle");
    check_val("s3_no_exc", {31'd0, exception_o}, 32'd0);
    step("s3_take");
    check_val("s3_exc", {31'd0, exception_o}, 32'd1);
    check_val("s3_ha", {13'd0, handler_address_o}, 32'h7fff2);
    check_val("s3_epc", {13'd0, epc_o}, 32'h200);

    // FIFO overflow, sticky flag and in-order drain
    do_reset();
    take_div0(19'h00001);
    step("s4_handler");
    for (int i = 0; i < 5; i++) begin
      valid_i = 1; ext_req_i = 2'b10; pc_i = 19'h00300 + 19'(i);
      step("s4_push");
    end
    check_val("s4_ovf_set", {31'd0, pend_ovf_o}, 32'd1);
    pc_i = 19'h00305; clr_sticky_i = 1;
    step("s4_drop_and_clr");
    check_val("s4_drop_wins", {31'd0, pend_ovf_o}, 32'd1);
    clear_inputs();
    clr_sticky_i = 1;
    step("s4_clr");
    check_val("s4_ovf_clr", {31'd0, pend_ovf_o}, 32'd0);
    clr_sticky_i = 0;
    for (int k = 0; k < 4; k++) begin
      eret_i = 1; step("s4_ret");
      eret_i = 0; step("s4_idle");
      step("s4_take");
      check_val("s4_drain_exc", {31'd0, exception_o}, 32'd1);
      check_val("s4_drain_epc", {13'd0, epc_o}, 32'h300 + k);
      check_val("s4_drain_cause", {30'd0, cause_o}, 32'd3);
      step("s4_handler");
    end
    eret_i = 1; step("s4_last_ret");
    eret_i = 0; step("s4_last_idle");
    step("s4_empty");
    check_val("s4_empty_busy", {31'd0, busy_o}, 32'd0);

    // Reset in the middle of a handler discards the queue
    do_reset();
    take_div0(19'h00010);
    step("s6_handler");
    for (int i = 0; i < 2; i++) begin
      valid_i = 1; ext_req_i = 2'b01; pc_i = 19'h00400 + 19'(i);
      step("s6_push");
    end
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("s6_busy_drop", {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("s6_after");
      check_val("s6_no_exc", {31'd0, exception_o}, 32'd0);
    end

    // Randomised traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      valid_i       = $urandom_range(0, 1);
      opcode_i      = 5'($urandom_range(0, 4));
      pc_i          = 19'($urandom);
      div_by_zero_i = ($urandom_range(0, 2) == 0);
      ovf_add_i     = ($urandom_range(0, 2) == 0);
      ovf_sub_i     = ($urandom_range(0, 2) == 0);
      ext_req_i     = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      mask_i        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      eret_i        = ($urandom_range(0, 4) == 0);
      clr_sticky_i  = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
